rv_decode_exec: RTL and testbench

//  RV32I decode/execute stage for the multi-cycle core. Decodes one instruction word

---
 rtl/rv_pkg.sv | 42 ++++
 rtl/rv_alu.sv | 37 +++
 rtl/rv_decode_exec.sv | 134 +++++++++++++
 tb/tb_rv_decode_exec.sv | 122 ++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: RV32I opcodes, control encodings and the funct3-to-ALU map shared by decode and ALU.
package rv_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
    ALU_SRA, ALU_OR, ALU_AND, ALU_EQ, ALU_NE, ALU_GE, ALU_GEU
  } alu_op_t;
  typedef enum logic [2:0] {RES_ALU, RES_IMM, RES_PC_IMM, RES_PC4, RES_MEM} result_src_t;
  typedef enum logic [1:0] {PC_PLUS4, PC_JAL, PC_JALR, PC_BRANCH} pc_src_t;
  typedef enum logic [2:0] {T_R, T_I, T_S, T_B, T_U, T_J} instr_type_t;
  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic alu_op_t branch_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_EQ;
      3'b001:  return ALU_NE;
      3'b100:  return ALU_SLT;
      3'b101:  return ALU_GE;
      3'b110:  return ALU_SLTU;
      3'b111:  return ALU_GEU;
      default: return ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/rv_alu.sv
// rv_alu: combinational RV32I ALU; compares return 1/0, shifts use in2[4:0].
module rv_alu
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic [XLEN-1:0] result
);
  logic [4:0] sh;
  logic lt, ltu;
  assign sh  = in2[4:0];
  assign lt  = $signed(in1) < $signed(in2);
  assign ltu = in1 < in2;
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = in1 + in2;
      ALU_SUB:  result = in1 - in2;
      ALU_SLL:  result = in1 << sh;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
      ALU_XOR:  result = in1 ^ in2;
      ALU_SRL:  result = in1 >> sh;
      ALU_SRA:  result = $unsigned($signed(in1) >>> sh);
      ALU_OR:   result = in1 | in2;
      ALU_AND:  result = in1 & in2;
      ALU_EQ:   result = {{(XLEN-1){1'b0}}, in1 == in2};
      ALU_NE:   result = {{(XLEN-1){1'b0}}, in1 != in2};
      ALU_GE:   result = {{(XLEN-1){1'b0}}, !lt};
      ALU_GEU:  result = {{(XLEN-1){1'b0}}, !ltu};
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/rv_decode_exec.sv
// rv_decode_exec: RV32I decode, immediate build and ALU, registered once (1-cycle latency).
module rv_decode_exec
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  output logic [1:0]      pc_src,
  output logic [2:0]      result_src,
  output logic [3:0]      alu_control,
  output logic            alu_src,
  output logic [2:0]      instruction_type,
  output logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] alu_result,
  output logic            illegal
);
  logic [6:0] opcode;
  logic [2:0] f3;
  pc_src_t pc_src_d;
  result_src_t res_d;
  alu_op_t alu_d;
  instr_type_t type_d;
  logic alu_src_d, illegal_d;
  logic [31:0] imm_d;
  logic [XLEN-1:0] alu_y;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  always_comb begin
    pc_src_d  = PC_PLUS4;
    res_d     = RES_ALU;
    alu_d     = ALU_ADD;
    type_d    = T_R;
    alu_src_d = 1'b0;
    illegal_d = 1'b0;
    case (opcode)
      OP_OP:     alu_d = arith_op(f3, instr[30]);
      OP_IMM: begin
        type_d    = T_I;
        alu_src_d = 1'b1;
        alu_d     = arith_op(f3, instr[30] && f3 == 3'b101);
      end
      OP_LOAD: begin
        type_d    = T_I;
        alu_src_d = 1'b1;
        res_d     = RES_MEM;
      end
      OP_STORE: begin
        type_d    = T_S;
        alu_src_d = 1'b1;
      end
      OP_BRANCH: begin
        type_d    = T_B;
        pc_src_d  = PC_BRANCH;
        alu_d     = branch_op(f3);
        illegal_d = f3[2:1] == 2'b01;
      end
      OP_LUI: begin
        type_d    = T_U;
        alu_src_d = 1'b1;
        res_d     = RES_IMM;
      end
      OP_AUIPC: begin
        type_d    = T_U;
        alu_src_d = 1'b1;
        res_d     = RES_PC_IMM;
      end
      OP_JAL: begin
        type_d    = T_J;
        alu_src_d = 1'b1;
        pc_src_d  = PC_JAL;
        res_d     = RES_PC4;
      end
      OP_JALR: begin
        type_d    = T_I;
        alu_src_d = 1'b1;
        pc_src_d  = PC_JALR;
        res_d     = RES_PC4;
      end
      default:   illegal_d = 1'b1;
    endcase
  end
  // R-type and unknown opcodes both land on T_R, whose immediate is zero.
  always_comb begin
    imm_d = '0;
    case (type_d)
      T_I:     imm_d = {{20{instr[31]}}, instr[31:20]};
      T_S:     imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      T_B:     imm_d = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      T_U:     imm_d = {instr[31:12], 12'b0};
      T_J:     imm_d = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_d = '0;
    endcase
  end
  rv_alu #(.XLEN(XLEN)) u_alu (
    .op     (alu_d),
    .in1    (rs1),
    .in2    (alu_src_d ? imm_d : rs2),
    .result (alu_y)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid        <= 1'b0;
      pc_src           <= '0;
      result_src       <= '0;
      alu_control      <= '0;
      alu_src          <= 1'b0;
      instruction_type <= '0;
      imm_ext          <= '0;
      alu_result       <= '0;
      illegal          <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        pc_src           <= pc_src_d;
        result_src       <= res_d;
        alu_control      <= alu_d;
        alu_src          <= alu_src_d;
        instruction_type <= type_d;
        imm_ext          <= imm_d;
        alu_result       <= alu_y;
        illegal          <= illegal_d;
      end
    end
  end
  logic unused_pc;
  assign unused_pc = ^pc;
endmodule

// File: tb/tb_rv_decode_exec.sv
// tb_rv_decode_exec: directed vectors pushed to a scoreboard queue, popped by a monitor on out_valid.
module tb_rv_decode_exec;
  typedef struct packed {
    logic [1:0]  pc_src;
    logic [2:0]  result_src;
    logic [3:0]  alu_control;
    logic        alu_src;
    logic [2:0]  itype;
    logic [31:0] imm;
    logic [31:0] res;
    logic        illegal;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [31:0] instr = '0, pc = 32'h1000, rs1 = '0, rs2 = '0;
  logic out_valid, alu_src, illegal;
  logic [1:0] pc_src;
  logic [2:0] result_src, instruction_type;
  logic [3:0] alu_control;
  logic [31:0] imm_ext, alu_result;
  exp_t got, last;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  rv_decode_exec dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .pc(pc), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .pc_src(pc_src), .result_src(result_src), .alu_control(alu_control),
    .alu_src(alu_src), .instruction_type(instruction_type), .imm_ext(imm_ext),
    .alu_result(alu_result), .illegal(illegal)
  );
  assign got = {pc_src, result_src, alu_control, alu_src, instruction_type, imm_ext, alu_result, illegal};
  function automatic exp_t mk(input logic [1:0] ps, input logic [2:0] rs, input logic [3:0] ac,
                              input logic as, input logic [2:0] ty, input logic [31:0] imm,
                              input logic [31:0] res, input logic ill);
    return '{ps, rs, ac, as, ty, imm, res, ill};
  endfunction
  task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    @(negedge clk);
    instr = i; rs1 = a; rs2 = b; in_valid = 1'b1;
    q.push_back(e);
    last = e;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #2;
    chk("queue_drained", 78'(q.size()), 78'd0);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_out_valid", 78'd1, 78'd0);
        else begin
          e = q.pop_front();
          chk("vector", got, e);
        end
      end
    end
  end
  initial begin : stim
    #1;
    chk("reset_outputs", got, '0);
    chk("reset_out_valid", 78'(out_valid), 78'd0);
    @(negedge clk);
    rst = 1'b0;
    send(32'h00208033, 32'd5, 32'd3, mk(0, 0, 0, 0, 0, 32'h0, 32'd8, 0));
    send(32'h40208033, 32'd5, 32'd3, mk(0, 0, 1, 0, 0, 32'h0, 32'd2, 0));
    send(32'h4040D093, 32'h80000000, 32'd0, mk(0, 0, 7, 1, 1, 32'h404, 32'hF8000000, 0));
    send(32'h12345037, 32'd0, 32'd0, mk(0, 1, 0, 1, 4, 32'h12345000, 32'h12345000, 0));
    send(32'h0020A423, 32'h100, 32'h55, mk(0, 0, 0, 1, 2, 32'd8, 32'h108, 0));
    send(32'hFE000EE3, 32'd7, 32'd7, mk(3, 0, 10, 0, 3, 32'hFFFFFFFC, 32'd1, 0));
    send(32'hFE000EE3, 32'd7, 32'd6, mk(3, 0, 10, 0, 3, 32'hFFFFFFFC, 32'd0, 0));
    send(32'h0020C463, 32'hFFFFFFFF, 32'd1, mk(3, 0, 3, 0, 3, 32'd8, 32'd1, 0));
    send(32'h008000EF, 32'd0, 32'd0, mk(1, 3, 0, 1, 5, 32'd8, 32'd8, 0));
    send(32'h00008067, 32'h200, 32'd0, mk(2, 3, 0, 1, 1, 32'd0, 32'h200, 0));
    send(32'hFFF00093, 32'd0, 32'd0, mk(0, 0, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0));
    send(32'h0040A083, 32'h10, 32'd0, mk(0, 4, 0, 1, 1, 32'd4, 32'h14, 0));
    send(32'h00001017, 32'd0, 32'd0, mk(0, 2, 0, 1, 4, 32'h1000, 32'h1000, 0));
    send(32'h0020B033, 32'd1, 32'hFFFFFFFF, mk(0, 0, 4, 0, 0, 32'd0, 32'd1, 0));
    send(32'h0000007F, 32'd1, 32'd2, mk(0, 0, 0, 0, 0, 32'd0, 32'd3, 1));
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      chk("idle_out_valid", 78'(out_valid), 78'd0);
      chk("idle_hold", got, last);
    end
    drain();
    send(32'h00208033, 32'd5, 32'd3, mk(0, 0, 0, 0, 0, 32'h0, 32'd8, 0));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", got, '0);
    chk("async_reset_out_valid", 78'(out_valid), 78'd0);
    instr = 32'h40208033; rs1 = 32'd9; rs2 = 32'd1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #2;
      chk("reset_held", got, '0);
      chk("reset_held_valid", 78'(out_valid), 78'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    send(32'h40208033, 32'd9, 32'd1, mk(0, 0, 1, 0, 0, 32'h0, 32'd8, 0));
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
